// File: rtl/completion_arbiter.sv
// rtl/completion_arbiter.sv - round-robin arbiter merging functional-unit completions into one ROB port
// Each requester owns a one-entry holding slot; only occupied slots compete, so there is no input-to-output path.
module completion_arbiter #(
    parameter int N_REQ           = 3,
    parameter int ROB_ENTRY_WIDTH = 4,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      flush_i,
    input  logic [N_REQ-1:0]                          req_valid_i,
    input  logic [N_REQ-1:0][ROB_ENTRY_WIDTH-1:0]     req_idx_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]          req_data_i,
    input  logic [N_REQ-1:0]                          req_excp_i,
    output logic [N_REQ-1:0]                          req_ready_o,
    output logic                                      instr_complete_valid_o,
    output logic [ROB_ENTRY_WIDTH-1:0]                instr_complete_idx_o,
    output logic [DATA_WIDTH-1:0]                     instr_complete_data_o,
    output logic                                      instr_excp_valid_o,
    output logic [N_REQ-1:0]                          grant_o
);

    localparam int              LG_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [LG_W-1:0] LAST_IDX = LG_W'(N_REQ - 1);

    logic [N_REQ-1:0]           slot_valid_q, slot_valid_d;
    logic [ROB_ENTRY_WIDTH-1:0] slot_idx_q  [N_REQ];
    logic [ROB_ENTRY_WIDTH-1:0] slot_idx_d  [N_REQ];
    logic [DATA_WIDTH-1:0]      slot_data_q [N_REQ];
    logic [DATA_WIDTH-1:0]      slot_data_d [N_REQ];
    logic [N_REQ-1:0]           slot_excp_q, slot_excp_d;
    logic [LG_W-1:0]            last_grant_q, last_grant_d;

    logic [LG_W-1:0]            cand;
    logic [LG_W-1:0]            sel;
    logic                       found;
    logic [N_REQ-1:0]           grant;
    logic [N_REQ-1:0]           ready;
    logic [N_REQ-1:0]           accept;

    // Walk the ports starting just after the last winner; first occupied slot wins.
    always_comb begin : arbitrate
        grant = '0;
        found = 1'b0;
        sel   = '0;
        cand  = last_grant_q;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + LG_W'(1);
            if (!found && !flush_i && slot_valid_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        if (found) begin
            grant[sel] = 1'b1;
        end
    end

    assign ready  = flush_i ? '0 : (~slot_valid_q | grant);
    assign accept = req_valid_i & ready;

    always_comb begin : next_state
        slot_valid_d = slot_valid_q;
        slot_idx_d   = slot_idx_q;
        slot_data_d  = slot_data_q;
        slot_excp_d  = slot_excp_q;
        last_grant_d = found ? sel : last_grant_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_idx_d[i]   = req_idx_i[i];
                slot_data_d[i]  = req_data_i[i];
                slot_excp_d[i]  = req_excp_i[i];
            end else if (grant[i]) begin
                slot_valid_d[i] = 1'b0;
            end
        end
        // A flush drops every held completion but keeps the fairness pointer.
        if (flush_i) begin
            slot_valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_valid_q <= '0;
            slot_excp_q  <= '0;
            last_grant_q <= LAST_IDX;
            for (int i = 0; i < N_REQ; i++) begin
                slot_idx_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_excp_q  <= slot_excp_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < N_REQ; i++) begin
                slot_idx_q[i]  <= slot_idx_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    assign req_ready_o            = ready;
    assign grant_o                = grant;
    assign instr_complete_valid_o = found;
    assign instr_complete_idx_o   = found ? slot_idx_q[sel] : '0;
    assign instr_complete_data_o  = found ? slot_data_q[sel] : '0;
    assign instr_excp_valid_o     = found ? slot_excp_q[sel] : 1'b0;

endmodule

// File: tb/tb_completion_arbiter.sv
// tb/tb_completion_arbiter.sv - directed vector table plus randomized run against a behavioural arbiter model
module tb_completion_arbiter;

    localparam int N = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0][3:0] req_idx_i;
    logic [N-1:0][31:0] req_data_i;
    logic [N-1:0]      req_excp_i;
    logic [N-1:0]      req_ready_o;
    logic              instr_complete_valid_o;
    logic [3:0]        instr_complete_idx_o;
    logic [31:0]       instr_complete_data_o;
    logic              instr_excp_valid_o;
    logic [N-1:0]      grant_o;

    completion_arbiter #(.N_REQ(N), .ROB_ENTRY_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .flush_i                (flush_i),
        .req_valid_i            (req_valid_i),
        .req_idx_i              (req_idx_i),
        .req_data_i             (req_data_i),
        .req_excp_i             (req_excp_i),
        .req_ready_o            (req_ready_o),
        .instr_complete_valid_o (instr_complete_valid_o),
        .instr_complete_idx_o   (instr_complete_idx_o),
        .instr_complete_data_o  (instr_complete_data_o),
        .instr_excp_valid_o     (instr_excp_valid_o),
        .grant_o                (grant_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0]       valid;
        logic [N-1:0][3:0]  idx;
        logic [N-1:0][31:0] data;
        logic [N-1:0]       excp;
        logic               flush;
        logic [N-1:0]       e_grant;
        logic               e_cv;
        logic [3:0]         e_idx;
        logic [31:0]        e_data;
        logic               e_excp;
        logic [N-1:0]       e_ready;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    bit          m_valid [N];
    logic [3:0]  m_idx   [N];
    logic [31:0] m_data  [N];
    bit          m_excp  [N];
    int          m_last;

    function automatic vec_t mk(input logic [2:0] v, input logic [3:0] i0, input logic [3:0] i1,
                                input logic [3:0] i2, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [2:0] ex, input logic fl,
                                input logic [2:0] eg, input logic ecv, input logic [3:0] eidx,
                                input logic [31:0] edata, input logic eexcp, input logic [2:0] erdy);
        vec_t r;
        r.valid = v;
        r.idx[0] = i0; r.idx[1] = i1; r.idx[2] = i2;
        r.data[0] = d0; r.data[1] = d1; r.data[2] = d2;
        r.excp = ex; r.flush = fl;
        r.e_grant = eg; r.e_cv = ecv; r.e_idx = eidx; r.e_data = edata;
        r.e_excp = eexcp; r.e_ready = erdy;
        return r;
    endfunction

    function automatic vec_t idle_row();
        return mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0, 3'b000, 1'b0, 0, 0, 1'b0, 3'b111);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag, input logic [2:0] eg, input logic ecv,
                               input logic [3:0] eidx, input logic [31:0] edata,
                               input logic eexcp, input logic [2:0] erdy);
        check({tag, ".grant"}, 32'(grant_o), 32'(eg));
        check({tag, ".valid"}, 32'(instr_complete_valid_o), 32'(ecv));
        check({tag, ".idx"},   32'(instr_complete_idx_o), 32'(eidx));
        check({tag, ".data"},  instr_complete_data_o, edata);
        check({tag, ".excp"},  32'(instr_excp_valid_o), 32'(eexcp));
        check({tag, ".ready"}, 32'(req_ready_o), 32'(erdy));
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_last = N - 1;
    endtask

    // Winner is the occupied port at the smallest cyclic distance past the last winner.
    function automatic int model_pick(input bit flush);
        int best;
        int d;
        int g;
        best = N;
        g = -1;
        if (!flush) begin
            for (int i = 0; i < N; i++) begin
                if (m_valid[i]) begin
                    d = (i - m_last - 1 + 2 * N) % N;
                    if (d < best) begin
                        best = d;
                        g = i;
                    end
                end
            end
        end
        return g;
    endfunction

    task automatic apply(input vec_t v, input bit from_tbl, input string tag);
        int g;
        logic [2:0] rdy;
        logic [2:0] eg;
        logic [3:0] eidx;
        logic [31:0] edata;
        logic eexcp;
        req_valid_i = v.valid;
        req_idx_i   = v.idx;
        req_data_i  = v.data;
        req_excp_i  = v.excp;
        flush_i     = v.flush;
        #3;
        g = model_pick(v.flush);
        for (int i = 0; i < N; i++) rdy[i] = !v.flush && (!m_valid[i] || g == i);
        eg = '0; eidx = '0; edata = '0; eexcp = 1'b0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            eidx  = m_idx[g];
            edata = m_data[g];
            eexcp = m_excp[g];
        end
        if (from_tbl)
            compare_all(tag, v.e_grant, v.e_cv, v.e_idx, v.e_data, v.e_excp, v.e_ready);
        else
            compare_all(tag, eg, g >= 0, eidx, edata, eexcp, rdy);
        @(posedge clk_i);
        if (v.flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (v.valid[i] && rdy[i]) begin
                    m_valid[i] = 1'b1;
                    m_idx[i]   = v.idx[i];
                    m_data[i]  = v.data[i];
                    m_excp[i]  = v.excp[i];
                end else if (g == i) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (g >= 0) m_last = g;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        rst_i = 1'b1;
        flush_i = 1'b0;
        req_valid_i = '0;
        req_idx_i = '0;
        req_data_i = '0;
        req_excp_i = '0;
        model_reset();
        #2;
        compare_all("reset", 3'b000, 1'b0, 4'd0, 32'd0, 1'b0, 3'b111);
        #10 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // simultaneous requests after reset
        tbl.push_back(mk(3'b111, 1, 2, 3, 'h11, 'h22, 'h33, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 1, 'h11, 0, 3'b001));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 2, 'h22, 0, 3'b011));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 3, 'h33, 0, 3'b111));
        tbl.push_back(idle_row());
        // single request on port 1
        tbl.push_back(mk(3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 5, 32'hDEADBEEF, 0, 3'b111));
        tbl.push_back(idle_row());
        // exception on port 2 with the top index
        tbl.push_back(mk(3'b100, 0, 0, 15, 0, 0, 32'hCAFEF00D, 3'b100, 0, 3'b000, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 15, 32'hCAFEF00D, 1, 3'b111));
        tbl.push_back(idle_row());
        // ports 0 and 2 streaming continuously
        tbl.push_back(mk(3'b101, 4, 0, 9, 'h100, 0, 'h200, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(3'b101, 4, 0, 9, 'h101, 0, 'h201, 0, 0, 3'b001, 1, 4, 'h100, 0, 3'b011));
        tbl.push_back(mk(3'b101, 4, 0, 9, 'h102, 0, 'h202, 0, 0, 3'b100, 1, 9, 'h200, 0, 3'b110));
        tbl.push_back(mk(3'b101, 4, 0, 9, 'h103, 0, 'h203, 0, 0, 3'b001, 1, 4, 'h101, 0, 3'b011));
        tbl.push_back(mk(3'b101, 4, 0, 9, 'h104, 0, 'h204, 0, 0, 3'b100, 1, 9, 'h202, 0, 3'b110));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 4, 'h103, 0, 3'b011));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 9, 'h204, 0, 3'b111));
        tbl.push_back(idle_row());
        // flush with slots 0 and 1 held; requests during flush are refused
        tbl.push_back(mk(3'b011, 3, 6, 0, 'h33, 'h66, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(3'b111, 7, 7, 7, 1, 2, 3, 0, 1, 3'b000, 0, 0, 0, 0, 3'b000));
        tbl.push_back(idle_row());
        tbl.push_back(idle_row());
        // pointer survives the flush: port 1 beats port 2
        tbl.push_back(mk(3'b110, 0, 8, 9, 0, 'h88, 'h99, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1, 8, 'h88, 0, 3'b011));
        tbl.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 9, 'h99, 0, 3'b111));

        foreach (tbl[k]) apply(tbl[k], 1'b1, $sformatf("row%0d", k));

        // asynchronous reset while slots 1 and 2 are held and last winner is port 0
        apply(mk(3'b001, 1, 0, 0, 'hA, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111), 1'b1, "mr0");
        apply(mk(3'b110, 0, 2, 3, 0, 'hB, 'hC, 0, 0, 3'b001, 1, 1, 'hA, 0, 3'b111), 1'b1, "mr1");
        req_valid_i = '0;
        #2;
        compare_all("mr_pre", 3'b010, 1'b1, 4'd2, 32'hB, 1'b0, 3'b011);
        rst_i = 1'b1;
        #1;
        compare_all("mr_rst", 3'b000, 1'b0, 4'd0, 32'd0, 1'b0, 3'b111);
        #1 rst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        apply(mk(3'b111, 1, 2, 3, 'hD, 'hE, 'hF, 0, 0, 3'b000, 0, 0, 0, 0, 3'b111), 1'b1, "mr2");
        apply(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 1, 'hD, 0, 3'b001), 1'b1, "mr3");

        for (int c = 0; c < 400; c++) begin
            v.valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                v.idx[i]  = 4'($urandom_range(0, 15));
                v.data[i] = $urandom;
            end
            v.excp  = 3'($urandom_range(0, 7));
            v.flush = ($urandom_range(0, 11) == 0);
            apply(v, 1'b0, $sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
